uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between NUM_REQ byte producers (e.g. debug console, status reporter, loopback echo).
- Selects one requester round-robin, optionally honours a per-requester lock for multi-byte packets, and drives uart_tx i_start/i_data.
- Tracks the transmitter's o_ready through each byte and flags a transmitter that never accepts a start.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte producers
// Optional macro UART_TX_ARB_PRIO0_EN makes requester 0 a strict high-priority requester.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_valid,
    input  logic [8*NUM_REQ-1:0] i_data,
    input  logic [NUM_REQ-1:0]   i_lock,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int LW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        last_q, last_d;
    logic [7:0]           cnt_q, cnt_d, cnt_inc;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 start_q, start_d;
    logic [7:0]           data_q, data_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [LW-1:0]        win;
    logic                 win_valid;
    logic                 win_upd_last;
    logic [LW:0]          rr_sum;
    logic [LW-1:0]        rr_idx;

    // Winner selection; the round-robin loop runs from the farthest candidate
    // down so the nearest valid requester after last is the final assignment.
    always_comb begin
        win          = last_q;
        win_valid    = 1'b0;
        win_upd_last = 1'b1;
        rr_sum       = '0;
        rr_idx       = '0;
`ifdef UART_TX_ARB_PRIO0_EN
        if (i_valid[0]) begin
            win          = '0;
            win_valid    = 1'b1;
            win_upd_last = 1'b0;
        end else
`endif
        if (i_lock[last_q] && i_valid[last_q]) begin
            win       = last_q;
            win_valid = 1'b1;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                rr_sum = {1'b0, last_q} + (LW+1)'(k);
                if (rr_sum >= (LW+1)'(NUM_REQ)) begin
                    rr_sum = rr_sum - (LW+1)'(NUM_REQ);
                end
                rr_idx = rr_sum[LW-1:0];
                if (i_valid[rr_idx]) begin
                    win       = rr_idx;
                    win_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 8'd1;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_tx_ready && win_valid) begin
                    ack_d[win] = 1'b1;
                    data_d     = i_data[{win, 3'b000} +: 8];
                    start_d    = 1'b1;
                    if (win_upd_last) begin
                        last_d = win;
                    end
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LW'(NUM_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a uart_tx ready model
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_valid;
    logic [8*N-1:0] i_data;
    logic [N-1:0] i_lock;
    logic [N-1:0] o_ack;
    logic         o_tx_start;
    logic [7:0]   o_tx_data;
    logic         i_tx_ready;
    logic         o_busy;
    logic         o_err;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_lock     (i_lock),
        .o_ack      (o_ack),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ack;
        logic [7:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    int   model_last = N - 1;
    int   frame_len = 4;
    int   busy_cnt = 0;
    bit   tx_stuck = 1'b0;
    bit   prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference arbitration rule: priority requester, then lock holder, then nearest after last.
    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] l, input int last);
`ifdef UART_TX_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        if (l[last] && v[last]) return last;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic predict();
        int   w;
        exp_t e;
        w = pick(i_valid, i_lock, model_last);
        if (w < 0) return;
`ifdef UART_TX_ARB_PRIO0_EN
        if (w != 0) model_last = w;
`else
        model_last = w;
`endif
        e.ack  = N'(1) << w;
        e.data = i_data[8*w +: 8];
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(output int w);
        w = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (o_ack != '0) begin
                for (int k = 0; k < N; k++) if (o_ack[k]) w = k;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: actual=none required=grant within 300 cycles");
        exp_q.delete();
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!o_busy) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: actual=busy required=idle within 300 cycles");
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ack"},   o_ack, 0);
        chk({tag, "_start"}, o_tx_start, 0);
        chk({tag, "_data"},  o_tx_data, 0);
        chk({tag, "_err"},   o_err, 0);
        chk({tag, "_busy"},  o_busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_valid = '0;
        i_lock = '0;
        tx_stuck = 1'b0;
        frame_len = 4;
        #1;
        chk_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // uart_tx stand-in: drops ready when it sees a start, raises it after frame_len cycles.
    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_tx_ready = 1'b1;
                busy_cnt = 0;
            end else if (i_tx_ready && o_tx_start && !tx_stuck) begin
                i_tx_ready = 1'b0;
                busy_cnt = frame_len;
            end else if (!i_tx_ready) begin
                if (busy_cnt <= 1) i_tx_ready = 1'b1;
                else busy_cnt--;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) chk("start_one_cycle", o_tx_start, 0);
                if (o_err) err_seen++;
                if (o_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: actual=%0b required=no grant", o_ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_ack", o_ack, e.ack);
                        chk("grant_data", o_tx_data, e.data);
                        chk("grant_start", o_tx_start, 1);
                    end
                    prev_ack = 1'b1;
                end else begin
                    prev_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        int n;
        int err_before;
        bit bad;
        int order2[6] = '{0, 1, 2, 3, 0, 1};
        int order3[5] = '{0, 1, 1, 1, 0};

        rst = 1'b1;
        i_valid = '0;
        i_lock = '0;
        i_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester: one-cycle latency and busy held through the frame.
        do_reset();
        i_data = 32'h0041_0000;
        i_valid = 4'b0100;
        predict();
        @(negedge clk);
        chk("t1_latency_ack", o_ack, 4'b0100);
        chk("t1_busy", o_busy, 1);
        i_valid = '0;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!i_tx_ready && !o_busy) bad = 1'b1;
            if (!o_busy) break;
        end
        chk("t1_busy_held", bad, 0);
        chk("t1_idle", o_busy, 0);

        // All requesters valid: plain rotation.
        do_reset();
        i_data = 32'h1312_1110;
        i_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            predict();
            wait_ack(w);
`ifndef UART_TX_ARB_PRIO0_EN
            chk("t2_order", w, order2[i]);
`endif
        end
        i_valid = '0;
        wait_idle();

        // Lock held by requester 1 across three grants, then released.
        do_reset();
        i_data = 32'h0000_B2A1;
        i_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) i_lock = 4'b0010;
            if (i == 4) i_lock = 4'b0000;
            predict();
            wait_ack(w);
`ifndef UART_TX_ARB_PRIO0_EN
            chk("t3_order", w, order3[i]);
`endif
        end
        i_valid = '0;
        wait_idle();

        // Transmitter never drops ready: timeout error, then recovery.
        do_reset();
        tx_stuck = 1'b1;
        i_data = 32'h0000_665A;
        i_valid = 4'b0001;
        err_before = err_seen;
        predict();
        wait_ack(w);
        i_valid = '0;
        chk("t4_start", o_tx_start, 1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (o_err) break;
        end
        chk("t4_err_delay", n, 16);
        chk("t4_idle_after_err", o_busy, 0);
        repeat (20) @(negedge clk);
        chk("t4_err_once", err_seen - err_before, 1);
        tx_stuck = 1'b0;
        i_valid = 4'b0010;
        predict();
        wait_ack(w);
        chk("t4_recover_grant", w, 1);
        i_valid = '0;
        wait_idle();

        // Reset while waiting for the frame to finish.
        do_reset();
        frame_len = 30;
        i_data = 32'h9900_0077;
        i_valid = 4'b0001;
        predict();
        wait_ack(w);
        i_valid = '0;
        repeat (5) @(negedge clk);
        chk("t5_in_wait_done", o_busy, 1);
        rst = 1'b1;
        #1;
        chk_zero_outputs("t5_midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        frame_len = 4;
        i_valid = 4'b1000;
        predict();
        wait_ack(w);
        chk("t5_first_grant", w, 3);
        i_valid = '0;
        wait_idle();

`ifdef UART_TX_ARB_PRIO0_EN
        do_reset();
        frame_len = 10;
        i_data = 32'h4433_2211;
        i_valid = 4'b1110;
        predict();
        wait_ack(w);
        chk("t6_first", w, 1);
        i_valid = 4'b1111;
        predict();
        wait_ack(w);
        chk("t6_prio", w, 0);
        i_valid = 4'b1110;
        predict();
        wait_ack(w);
        chk("t6_rr_resume", w, 2);
        i_valid = '0;
        wait_idle();
`endif

        // Randomized requests, locks, data and frame lengths.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            i_valid = N'($urandom_range(1, 15));
            i_lock = N'($urandom);
            i_data = $urandom;
            frame_len = $urandom_range(1, 6);
            predict();
            wait_ack(w);
        end
        i_valid = '0;
        i_lock = '0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
